// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port valid/ready sequencer and NZCV owner in front of a shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; default build uses fixed priority (port 0 wins).
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_val1,
    input  logic [WIDTH-1:0] req0_val2,
    input  logic [3:0]       req0_cmd,
    input  logic             req0_s,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_val1,
    input  logic [WIDTH-1:0] req1_val2,
    input  logic [3:0]       req1_cmd,
    input  logic             req1_s,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [3:0]       rsp0_status,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [3:0]       rsp1_status,
    output logic [WIDTH-1:0] alu_val1,
    output logic [WIDTH-1:0] alu_val2,
    output logic [3:0]       alu_exe_cmd,
    output logic             alu_c,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_status,
    output logic [3:0]       status_reg
);
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned NZCV_W = 4;
    localparam int unsigned C_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                grant_c;
    logic                accept_c;
    logic                owner;
    logic [WIDTH-1:0]    val1_q;
    logic [WIDTH-1:0]    val2_q;
    logic [CMD_W-1:0]    cmd_q;
    logic                s_q;
    logic [WIDTH-1:0]    result_q;
    logic [NZCV_W-1:0]   rstat_q;
    logic [NZCV_W-1:0]   status_q;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // On a tie the port not granted last wins; reset points at port 1 so port 0 wins first.
    assign grant_c = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept_c) begin
            last_grant <= grant_c;
        end
    end
`else
    assign grant_c = ~req0_valid & req1_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Single outstanding op: accept only in IDLE, respond to the owner only in RESP.
    always_comb begin
        state_nxt  = state;
        accept_c   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid & ~grant_c;
                req1_ready = req1_valid & grant_c;
                if (req0_valid || req1_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if (owner ? rsp1_ready : rsp0_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= 1'b0;
            val1_q <= '0;
            val2_q <= '0;
            cmd_q  <= '0;
            s_q    <= 1'b0;
        end else if (accept_c) begin
            owner  <= grant_c;
            val1_q <= grant_c ? req1_val1 : req0_val1;
            val2_q <= grant_c ? req1_val2 : req0_val2;
            cmd_q  <= grant_c ? req1_cmd  : req0_cmd;
            s_q    <= grant_c ? req1_s    : req0_s;
        end
    end

    // Result capture and architectural flag update at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            rstat_q  <= '0;
            status_q <= '0;
        end else if (state == EXEC) begin
            result_q <= alu_out;
            rstat_q  <= alu_status;
            if (s_q) begin
                status_q <= alu_status;
            end
        end
    end

    assign alu_val1    = val1_q;
    assign alu_val2    = val2_q;
    assign alu_exe_cmd = cmd_q;
    assign alu_c       = status_q[C_BIT];
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_status = rstat_q;
    assign rsp1_status = rstat_q;
    assign status_reg  = status_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test of alu_arbiter with a small ADD/ADC/MOV ALU model attached.
module tb_alu_arbiter;
    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_val1, req0_val2, req1_val1, req1_val2;
    logic [3:0]       req0_cmd, req1_cmd;
    logic             req0_s, req1_s;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic [3:0]       rsp0_status, rsp1_status;
    logic [WIDTH-1:0] alu_val1, alu_val2, alu_out;
    logic [3:0]       alu_exe_cmd, alu_status, status_reg;
    logic             alu_c;
    logic [WIDTH:0]   alu_sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_val1(req0_val1),
        .req0_val2(req0_val2), .req0_cmd(req0_cmd), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_val1(req1_val1),
        .req1_val2(req1_val2), .req1_cmd(req1_cmd), .req1_s(req1_s),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_status(rsp0_status),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_status(rsp1_status),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_exe_cmd(alu_exe_cmd), .alu_c(alu_c),
        .alu_out(alu_out), .alu_status(alu_status), .status_reg(status_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: 0001 MOV (val2), 0010 ADD, 0011 ADC, others pass val1.
    always_comb begin
        alu_sum = '0;
        alu_out = alu_val1;
        alu_status = '0;
        case (alu_exe_cmd)
            4'b0001: alu_out = alu_val2;
            4'b0010: alu_sum = {1'b0, alu_val1} + {1'b0, alu_val2};
            4'b0011: alu_sum = {1'b0, alu_val1} + {1'b0, alu_val2} + 33'(alu_c);
            default: alu_out = alu_val1;
        endcase
        if (alu_exe_cmd == 4'b0010 || alu_exe_cmd == 4'b0011) begin
            alu_out = alu_sum[WIDTH-1:0];
            alu_status[1] = alu_sum[WIDTH];
            alu_status[0] = (alu_val1[WIDTH-1] == alu_val2[WIDTH-1]) &&
                            (alu_out[WIDTH-1] != alu_val1[WIDTH-1]);
        end
        alu_status[3] = alu_out[WIDTH-1];
        alu_status[2] = (alu_out == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rvalid(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [3:0] cmd,
                           input logic [31:0] v1, input logic [31:0] v2, input logic s);
        if (p == 1) begin
            req1_valid = v; req1_cmd = cmd; req1_val1 = v1; req1_val2 = v2; req1_s = s;
        end else begin
            req0_valid = v; req0_cmd = cmd; req0_val1 = v1; req0_val2 = v2; req0_s = s;
        end
    endtask

    // Issue one op and return one cycle into RESP, checking the accept/exec/resp timing.
    task automatic issue(input int p, input logic [3:0] cmd, input logic [31:0] v1,
                         input logic [31:0] v2, input logic s, input logic exp_c);
        logic ok;
        ok = 1'b0;
        set_req(p, 1'b1, cmd, v1, v2, s);
        #1;
        for (int k = 0; k < 20; k++) begin
            if (rdy(p)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("accept_wait", 64'(ok), 64'(1));
        @(posedge clk); #1;
        if (p == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        check("exec_cmd", 64'(alu_exe_cmd), 64'(cmd));
        check("exec_val1", 64'(alu_val1), 64'(v1));
        check("exec_carry", 64'(alu_c), 64'(exp_c));
        check("exec_no_rsp", 64'(rvalid(p)), 64'(0));
        @(posedge clk); #1;
        check("rsp_latency", 64'(rvalid(p)), 64'(1));
    endtask

    task automatic collect(input int p, input logic [31:0] exp_res, input logic [3:0] exp_st,
                           input logic [3:0] exp_sreg);
        check("rsp_result", 64'((p == 1) ? rsp1_result : rsp0_result), 64'(exp_res));
        check("rsp_status", 64'((p == 1) ? rsp1_status : rsp0_status), 64'(exp_st));
        check("status_reg", 64'(status_reg), 64'(exp_sreg));
        check("other_rsp_low", 64'(rvalid(1 - p)), 64'(0));
        if (p == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("rsp_dropped", 64'(rvalid(p)), 64'(0));
    endtask

    int order [8];
    int acc_cyc [8];
    int exp_order [8];

    initial begin
        int n0, n1, ng;
        logic g0, g1;
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0_ready", 64'(req0_ready), 64'(0));
        check("rst_rsp0_valid", 64'(rsp0_valid), 64'(0));
        check("rst_rsp1_valid", 64'(rsp1_valid), 64'(0));
        check("rst_status_reg", 64'(status_reg), 64'(0));
        check("rst_alu_cmd", 64'(alu_exe_cmd), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed overflow ADD with flag update.
        issue(0, 4'b0010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
        collect(0, 32'hFFFF_FFFE, 4'b1001, 4'b1001);

        // Carry chaining: ADD sets C, ADC consumes it without updating flags.
        issue(0, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        collect(0, 32'h0000_0000, 4'b0110, 4'b0110);
        issue(0, 4'b0011, 32'h0, 32'h0, 1'b0, 1'b1);
        collect(0, 32'h0000_0001, 4'b0000, 4'b0110);

        // MOV without status update from port 1.
        issue(1, 4'b0001, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        collect(1, 32'h0, 4'b0100, 4'b0110);

        // Both ports contend for four ops each with responses always taken.
`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        for (int i = 0; i < 8; i++) begin
            order[i] = 3;
            acc_cyc[i] = 0;
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 4'b0010, 32'h1, 32'h2, 1'b0);
        set_req(1, 1'b1, 4'b0010, 32'h3, 32'h4, 1'b0);
        n0 = 0; n1 = 0; ng = 0;
        for (int k = 0; k < 80 && ng < 8; k++) begin
            if (n0 == 4) req0_valid = 1'b0;
            if (n1 == 4) req1_valid = 1'b0;
            #1;
            g0 = req0_valid & req0_ready;
            g1 = req1_valid & req1_ready;
            @(posedge clk); #1;
            if (g0) begin
                order[ng] = 0; acc_cyc[ng] = cyc; ng++; n0++;
            end else if (g1) begin
                order[ng] = 1; acc_cyc[ng] = cyc; ng++; n1++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("arb_count", 64'(ng), 64'(8));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("arb_grant%0d", i), 64'(order[i]), 64'(exp_order[i]));
        end
        for (int i = 1; i < 8; i++) begin
            check($sformatf("arb_spacing%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(3));
        end
        repeat (3) @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("arb_idle", 64'(rsp0_valid | rsp1_valid), 64'(0));

        // Backpressure on port 1 while both ports keep requesting.
        issue(1, 4'b0010, 32'h5, 32'h3, 1'b0, 1'b1);
        set_req(0, 1'b1, 4'b0001, 32'h0, 32'hA5, 1'b0);
        set_req(1, 1'b1, 4'b0001, 32'h0, 32'h77, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_rsp1_valid", 64'(rsp1_valid), 64'(1));
            check("bp_rsp1_result", 64'(rsp1_result), 64'(8));
            check("bp_req_ready", 64'({req0_ready, req1_ready}), 64'(0));
        end
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        check("bp_released", 64'(rsp1_valid), 64'(0));
        check("bp_resume_ready0", 64'(req0_ready), 64'(1));
        check("bp_resume_ready1", 64'(req1_ready), 64'(0));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_next_rsp0", 64'(rsp0_valid), 64'(1));
        collect(0, 32'hA5, 4'b0000, 4'b0110);

        // Reset asserted mid-EXEC drops the op and its flag update.
        set_req(0, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        #1;
        check("rst_pre_ready", 64'(req0_ready), 64'(1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #1;
        check("rst_pre_exec", 64'(alu_exe_cmd), 64'(4'b0010));
        rst_n = 1'b0;
        #1;
        check("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
        check("rst_valid", 64'({rsp0_valid, rsp1_valid}), 64'(0));
        check("rst_result", 64'(rsp0_result | rsp1_result), 64'(0));
        check("rst_status", 64'({rsp0_status, rsp1_status}), 64'(0));
        check("rst_sreg", 64'(status_reg), 64'(0));
        check("rst_alu", 64'({alu_val1, alu_val2}), 64'(0));
        check("rst_alu_cmd_c", 64'({alu_exe_cmd, alu_c}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_sreg", 64'(status_reg), 64'(0));
        check("post_rst_idle", 64'({rsp0_valid, rsp1_valid}), 64'(0));
        issue(1, 4'b0001, 32'h0, 32'h5A, 1'b1, 1'b0);
        collect(1, 32'h5A, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
